// File: rtl/btb_update_sched_if.sv
// btb_update_sched_if
//   Handshake/bus bundle between the EX stage, the pre-decoder, the BTB write
//   port and the update scheduler.
//   slave  : scheduler side (consumes EX/pre-decode requests, drives wr_*)
//   master : environment side (EX, pre-decoder, table storage, flush source)
//   Signals:
//     ex_*       EX branch resolution (valid, pc, target, taken, fail flags)
//     pd_*       pre-decode correction (valid, pc, btype) and pd_ready back
//     flush_req  whole-table invalidate pulse; clear_busy while clearing
//     tbl_ready  table write port free; wr_* write request fields
//     ex_drop    EX update discarded this cycle
interface btb_update_sched_if #(
    parameter int PC_INDEX_WIDTH = 6,
    parameter int TAG_WIDTH      = 8
);
    logic                      ex_valid;
    logic [31:0]               ex_pc;
    logic [31:0]               ex_tpc;
    logic                      ex_taken;
    logic                      ex_dir_fail;
    logic                      ex_add_fail;
    logic                      pd_valid;
    logic [31:0]               pd_pc;
    logic [1:0]                pd_btype;
    logic                      pd_ready;
    logic                      flush_req;
    logic                      clear_busy;
    logic                      tbl_ready;
    logic                      wr_en;
    logic [PC_INDEX_WIDTH-1:0] wr_index;
    logic [TAG_WIDTH-1:0]      wr_tag;
    logic [29:0]               wr_target;
    logic                      wr_taken;
    logic [1:0]                wr_btype;
    logic                      wr_valid;
    logic                      wr_src;
    logic                      ex_drop;

    modport master (
        output ex_valid, ex_pc, ex_tpc, ex_taken, ex_dir_fail, ex_add_fail,
        output pd_valid, pd_pc, pd_btype, flush_req, tbl_ready,
        input  pd_ready, clear_busy, wr_en, wr_index, wr_tag, wr_target,
        input  wr_taken, wr_btype, wr_valid, wr_src, ex_drop
    );

    modport slave (
        input  ex_valid, ex_pc, ex_tpc, ex_taken, ex_dir_fail, ex_add_fail,
        input  pd_valid, pd_pc, pd_btype, flush_req, tbl_ready,
        output pd_ready, clear_busy, wr_en, wr_index, wr_tag, wr_target,
        output wr_taken, wr_btype, wr_valid, wr_src, ex_drop
    );
endinterface

// File: rtl/btb_update_sched.sv
// btb_update_sched
//   Schedules BTB table writes onto the single write port: EX misprediction
//   updates (coalescing FIFO), pre-decode corrections (one holding register,
//   starvation-protected), and a full-table clear after reset or flush.
//   Ports:
//     clk   clock
//     rstn  synchronous active-low reset
//     bus   btb_update_sched_if.slave (EX / pre-decode / write-port bundle)
//   Optional feature macro BTB_UPD_STAT_EN adds:
//     stat_wr_cnt[31:0]    saturating count of table transfers while running
//     stat_drop_cnt[31:0]  saturating count of ex_drop cycles
module btb_update_sched #(
    parameter int PC_INDEX_WIDTH = 6,
    parameter int TAG_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                clk,
    input  logic                rstn,
    btb_update_sched_if.slave   bus
`ifdef BTB_UPD_STAT_EN
    ,
    output logic [31:0]         stat_wr_cnt,
    output logic [31:0]         stat_drop_cnt
`endif
);
    localparam int IW = PC_INDEX_WIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   clr_cnt, clr_cnt_nxt;

    // EX update FIFO
    logic [IW-1:0]   f_idx   [FIFO_DEPTH];
    logic [TW-1:0]   f_tag   [FIFO_DEPTH];
    logic [29:0]     f_tgt   [FIFO_DEPTH];
    logic            f_taken [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, newest;
    logic [PW:0]     count;

    // pre-decode holding register
    logic            pd_full;
    logic [IW-1:0]   pd_idx;
    logic [TW-1:0]   pd_tag;
    logic [1:0]      pd_btype_r;

    logic [SW-1:0]   starve_cnt;
    // Source presented while the port stalls; kept so wr_* cannot switch
    // source before the transfer completes.
    logic            lock_vld, lock_pd;

    logic            run, flush_run, ex_q, fifo_empty, fifo_full;
    logic            sel_pd, xfer, pop_ex, pop_pd, coalesce, push, pd_load;
    logic [IW-1:0]   ex_idx;
    logic [TW-1:0]   ex_tag;
    logic            unused_pc_bits;

    assign run        = (state == RUN);
    assign flush_run  = run && bus.flush_req;
    assign ex_idx     = bus.ex_pc[IW+2:3];
    assign ex_tag     = bus.ex_pc[IW+TW+2:IW+3];
    assign ex_q       = bus.ex_valid && (bus.ex_dir_fail || bus.ex_add_fail);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign newest     = wr_ptr - PW'(1);

    assign unused_pc_bits = ^{bus.ex_pc[31:IW+TW+3], bus.ex_pc[2:0],
                              bus.pd_pc[31:IW+TW+3], bus.pd_pc[2:0],
                              bus.ex_tpc[1:0]};

    always_comb begin
        if (lock_vld)
            sel_pd = lock_pd;
        else
            sel_pd = pd_full && (fifo_empty || starve_cnt == SW'(STARVE_LIMIT));
    end

    assign xfer    = bus.wr_en && bus.tbl_ready;
    assign pop_ex  = run && xfer && !sel_pd;
    assign pop_pd  = run && xfer && sel_pd;
    // Overwrite the newest entry unless it is the sole entry leaving now.
    assign coalesce = run && ex_q && !fifo_empty && (f_idx[newest] == ex_idx)
                      && !(pop_ex && count == (PW+1)'(1));
    assign push    = run && ex_q && !bus.flush_req && !coalesce
                     && (!fifo_full || pop_ex);
    assign pd_load = run && !bus.flush_req && bus.pd_valid && !pd_full;

    assign bus.ex_drop = ex_q && (!run || bus.flush_req
                                  || (!coalesce && fifo_full && !pop_ex));

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (bus.flush_req) begin
                    clr_cnt_nxt = '0;
                end else if (xfer) begin
                    if (clr_cnt == '1) begin
                        state_nxt   = RUN;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + IW'(1);
                    end
                end
            end
            RUN: begin
                if (bus.flush_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // write-port outputs
    always_comb begin
        bus.wr_en      = 1'b0;
        bus.wr_index   = '0;
        bus.wr_tag     = '0;
        bus.wr_target  = '0;
        bus.wr_taken   = 1'b0;
        bus.wr_btype   = 2'b00;
        bus.wr_valid   = 1'b0;
        bus.wr_src     = 1'b0;
        bus.clear_busy = 1'b0;
        bus.pd_ready   = 1'b0;
        case (state)
            CLEAR: begin
                bus.clear_busy = 1'b1;
                bus.wr_en      = rstn;
                bus.wr_index   = clr_cnt;
            end
            RUN: begin
                bus.pd_ready = !pd_full;
                if (sel_pd) begin
                    bus.wr_en    = rstn;
                    bus.wr_index = pd_idx;
                    bus.wr_tag   = pd_tag;
                    bus.wr_taken = pd_btype_r[0];
                    bus.wr_btype = pd_btype_r;
                    bus.wr_valid = (pd_btype_r != 2'b00);
                    bus.wr_src   = 1'b1;
                end else if (!fifo_empty) begin
                    bus.wr_en     = rstn;
                    bus.wr_index  = f_idx[rd_ptr];
                    bus.wr_tag    = f_tag[rd_ptr];
                    bus.wr_target = f_tgt[rd_ptr];
                    bus.wr_taken  = f_taken[rd_ptr];
                    bus.wr_btype  = 2'b10;
                    bus.wr_valid  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // queue / holding register control
    always_ff @(posedge clk) begin
        if (!rstn || flush_run) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pd_full    <= 1'b0;
            starve_cnt <= '0;
            lock_vld   <= 1'b0;
            lock_pd    <= 1'b0;
        end else if (run) begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ex)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop_ex);
            if (pop_pd)
                pd_full <= 1'b0;
            else if (pd_load)
                pd_full <= 1'b1;
            if (pop_pd)
                starve_cnt <= '0;
            else if (pd_full && pop_ex && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
            lock_vld <= bus.wr_en && !bus.tbl_ready;
            lock_pd  <= sel_pd;
        end
    end

    // payload storage
    always_ff @(posedge clk) begin
        if (coalesce && !bus.flush_req) begin
            f_idx[newest]   <= ex_idx;
            f_tag[newest]   <= ex_tag;
            f_tgt[newest]   <= bus.ex_tpc[31:2];
            f_taken[newest] <= bus.ex_taken;
        end
        if (push) begin
            f_idx[wr_ptr]   <= ex_idx;
            f_tag[wr_ptr]   <= ex_tag;
            f_tgt[wr_ptr]   <= bus.ex_tpc[31:2];
            f_taken[wr_ptr] <= bus.ex_taken;
        end
        if (pd_load) begin
            pd_idx     <= bus.pd_pc[IW+2:3];
            pd_tag     <= bus.pd_pc[IW+TW+2:IW+3];
            pd_btype_r <= bus.pd_btype;
        end
    end

`ifdef BTB_UPD_STAT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_wr_cnt   <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (run && xfer && stat_wr_cnt != '1)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (bus.ex_drop && stat_drop_cnt != '1)
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;
    localparam int IW    = 6;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int LIM   = 3;
    localparam int NIDX  = 1 << IW;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    btb_update_sched_if #(.PC_INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

`ifdef BTB_UPD_STAT_EN
    logic [31:0] stat_wr_cnt, stat_drop_cnt;
`endif

    btb_update_sched #(
        .PC_INDEX_WIDTH(IW),
        .TAG_WIDTH     (TW),
        .FIFO_DEPTH    (DEPTH),
        .STARVE_LIMIT  (LIM)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
`ifdef BTB_UPD_STAT_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        int tag;
        int tgt;
        bit taken;
    } ent_t;

    ent_t q[$];
    bit   m_known = 0;
    bit   m_clear;
    int   m_cnt;
    bit   m_pd_full;
    int   m_pd_idx, m_pd_tag;
    bit [1:0] m_pd_bt;
    int   m_starve;
    bit   m_hold, m_hold_pd;
    int   m_stat_wr, m_stat_drop;

    // observations from the most recent cycle, used by directed scenarios
    bit o_wr_en, o_xfer, o_src, o_valid, o_taken, o_drop, o_cb, o_pdr;
    int o_idx, o_tgt;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 3) % NIDX);
    endfunction

    function automatic int pc_tag(input logic [31:0] pc);
        return int'((pc >> (IW + 3)) % (1 << TW));
    endfunction

    task automatic model_reset();
        m_known = 1; m_clear = 1; m_cnt = 0;
        q.delete();
        m_pd_full = 0; m_starve = 0; m_hold = 0; m_hold_pd = 0;
        m_stat_wr = 0; m_stat_drop = 0;
    endtask

    // One clock cycle: compare settled outputs to the model, take the edge,
    // advance the model, return to the falling edge for new stimulus.
    task automatic tick();
        bit   ex_q, e_wr_en, e_drop, e_pdr, e_cb, e_sel, e_tk, e_val, e_src;
        bit   xfer, popx, popp, coal, full, pd_was_full;
        bit [1:0] e_bt;
        int   e_idx, e_tag, e_tgt;
        ent_t ne;
        #1;
        o_wr_en = bus.wr_en;
        o_xfer  = bus.wr_en && bus.tbl_ready;
        o_src   = bus.wr_src;
        o_valid = bus.wr_valid;
        o_taken = bus.wr_taken;
        o_drop  = bus.ex_drop;
        o_cb    = bus.clear_busy;
        o_pdr   = bus.pd_ready;
        o_idx   = int'(bus.wr_index);
        o_tgt   = int'(bus.wr_target);

        ex_q = bus.ex_valid && (bus.ex_dir_fail || bus.ex_add_fail);
        ne.idx = pc_idx(bus.ex_pc); ne.tag = pc_tag(bus.ex_pc);
        ne.tgt = int'(bus.ex_tpc >> 2); ne.taken = bus.ex_taken;
        e_sel = 0; xfer = 0; popx = 0; popp = 0; coal = 0; e_drop = 0;

        if (!rstn) begin
            check("wr_en_in_reset", bus.wr_en, 0);
        end else if (m_known) begin
            e_idx = 0; e_tag = 0; e_tgt = 0; e_tk = 0; e_bt = 0; e_val = 0; e_src = 0;
            if (m_clear) begin
                e_wr_en = 1; e_idx = m_cnt; e_cb = 1; e_pdr = 0; e_drop = ex_q;
                xfer = bus.tbl_ready;
            end else begin
                e_sel = m_hold ? m_hold_pd : (m_pd_full && (q.size() == 0 || m_starve == LIM));
                e_cb = 0; e_pdr = !m_pd_full;
                if (e_sel) begin
                    e_idx = m_pd_idx; e_tag = m_pd_tag; e_tk = m_pd_bt[0]; e_bt = m_pd_bt;
                    e_val = (m_pd_bt != 0); e_src = 1;
                end else if (q.size() > 0) begin
                    e_idx = q[0].idx; e_tag = q[0].tag; e_tgt = q[0].tgt; e_tk = q[0].taken;
                    e_bt = 2'b10; e_val = 1;
                end
                e_wr_en = e_sel || (q.size() > 0);
                xfer = e_wr_en && bus.tbl_ready;
                popx = xfer && !e_sel;
                popp = xfer && e_sel;
                coal = ex_q && q.size() > 0 && q[$].idx == ne.idx && !(popx && q.size() == 1);
                full = (q.size() == DEPTH);
                e_drop = ex_q && (bus.flush_req || (!coal && full && !popx));
            end
            check("wr_en", bus.wr_en, e_wr_en);
            if (e_wr_en) begin
                check("wr_index", bus.wr_index, e_idx);
                check("wr_tag", bus.wr_tag, e_tag);
                check("wr_target", bus.wr_target, e_tgt);
                check("wr_taken", bus.wr_taken, e_tk);
                check("wr_btype", bus.wr_btype, e_bt);
                check("wr_valid", bus.wr_valid, e_val);
                check("wr_src", bus.wr_src, e_src);
            end
            check("ex_drop", bus.ex_drop, e_drop);
            check("pd_ready", bus.pd_ready, e_pdr);
            check("clear_busy", bus.clear_busy, e_cb);
        end

        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (m_known) begin
            if (e_drop) m_stat_drop++;
            if (m_clear) begin
                if (bus.flush_req) m_cnt = 0;
                else if (xfer) begin
                    if (m_cnt == NIDX - 1) begin m_clear = 0; m_cnt = 0; end
                    else m_cnt++;
                end
            end else begin
                if (xfer) m_stat_wr++;
                if (bus.flush_req) begin
                    m_clear = 1; m_cnt = 0; q.delete();
                    m_pd_full = 0; m_starve = 0; m_hold = 0;
                end else begin
                    full = (q.size() == DEPTH);
                    if (coal) q[q.size() - 1] = ne;
                    if (popx) void'(q.pop_front());
                    if (ex_q && !coal && (!full || popx)) q.push_back(ne);
                    pd_was_full = m_pd_full;
                    if (popp) m_pd_full = 0;
                    else if (bus.pd_valid && !pd_was_full) begin
                        m_pd_full = 1;
                        m_pd_idx = pc_idx(bus.pd_pc);
                        m_pd_tag = pc_tag(bus.pd_pc);
                        m_pd_bt  = bus.pd_btype;
                    end
                    if (popp) m_starve = 0;
                    else if (pd_was_full && popx && m_starve < LIM) m_starve++;
                    m_hold = e_wr_en && !bus.tbl_ready;
                    m_hold_pd = e_sel;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_tpc = 0; bus.ex_taken = 0;
        bus.ex_dir_fail = 0; bus.ex_add_fail = 0;
        bus.pd_valid = 0; bus.pd_pc = 0; bus.pd_btype = 0;
        bus.flush_req = 0;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] tpc, input bit tk);
        bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_tpc = tpc; bus.ex_taken = tk;
        bus.ex_dir_fail = 1; bus.ex_add_fail = 0;
    endtask

    // reset then complete the clear sequence with the port always ready
    task automatic reset_to_run();
        idle();
        bus.tbl_ready = 1;
        rstn = 0;
        tick();
        rstn = 1;
        for (int i = 0; i < NIDX; i++) tick();
    endtask

    localparam logic [31:0] BASE = 32'h1C00_0000;

    initial begin
        int n, cnt, tgt;
        bit found, tk;
        int got[$];

        rstn = 0;
        idle();
        bus.tbl_ready = 1;
        @(negedge clk);
        tick();
        tick();

        // ---- reset + full clear ----
        rstn = 1;
        n = 0;
        for (int i = 0; i < NIDX; i++) begin
            tick();
            if (i == 0) check("clear_first_index", o_idx, 0);
            if (o_xfer && !o_valid && o_cb) n++;
        end
        check("clear_write_count", n, NIDX);
        tick();
        check("run_clear_busy", o_cb, 0);
        check("run_pd_ready", o_pdr, 1);

        // ---- FIFO full / drop / order ----
        bus.tbl_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_ex(BASE | 32'((10 + i) << 3), BASE + 32'h400 + 32'(i * 4), 1);
            tick();
            if (i == 3) check("fifo_4th_no_drop", o_drop, 0);
            if (i == 4) check("fifo_5th_drop", o_drop, 1);
        end
        idle();
        bus.tbl_ready = 1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_xfer && !o_src) got.push_back(o_idx);
        end
        check("fifo_drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("fifo_order", got[i], 10 + i);

        // ---- coalescing ----
        bus.tbl_ready = 0;
        set_ex(32'h1C00_0040, 32'h1C00_0100, 1);
        tick();
        set_ex(32'h1C00_0040, 32'h1C00_0200, 1);
        tick();
        idle();
        bus.tbl_ready = 1;
        cnt = 0; tgt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_xfer && !o_src) begin cnt++; tgt = o_tgt; end
        end
        check("coalesce_writes", cnt, 1);
        check("coalesce_target", tgt, 32'h1C00_0200 >> 2);

        // ---- pre-decode starvation limit ----
        for (int i = 0; i < 2; i++) begin
            set_ex(BASE | 32'((20 + i) << 3), BASE + 32'h800, 0);
            tick();
        end
        set_ex(BASE | 32'(22 << 3), BASE + 32'h800, 0);
        bus.pd_valid = 1; bus.pd_pc = 32'h1C00_0008; bus.pd_btype = 2'b01;
        tick();
        bus.pd_valid = 0;
        cnt = 0; found = 0; tk = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            set_ex(BASE | 32'((23 + k) << 3), BASE + 32'h900, 0);
            tick();
            if (o_xfer && o_src) begin found = 1; tk = o_taken; end
            else if (o_xfer) cnt++;
        end
        check("starve_pd_granted", found, 1);
        check("starve_ex_xfers", cnt, LIM);
        check("starve_pd_taken", tk, 1);
        idle();
        for (int i = 0; i < 6; i++) tick();

        // ---- flush with two queued ----
        bus.tbl_ready = 0;
        set_ex(BASE | 32'(40 << 3), BASE + 32'hA00, 1); tick();
        set_ex(BASE | 32'(41 << 3), BASE + 32'hA00, 1); tick();
        idle();
        bus.flush_req = 1; tick();
        bus.flush_req = 0;
        bus.tbl_ready = 1;
        tick();
        check("flush_clear_busy", o_cb, 1);
        check("flush_restart_index", o_idx, 0);
        n = 0;
        for (int i = 0; i < NIDX + 2; i++) begin
            tick();
            if (o_xfer && o_valid) n++;
        end
        check("flush_no_ex_writes", n, 0);

        // ---- reset pulse mid-clear ----
        rstn = 0; tick(); rstn = 1;
        for (int i = 0; i < 30; i++) tick();
        rstn = 0;
        tick();
        check("midclear_rst_wr_en", o_wr_en, 0);
        rstn = 1;
        tick();
        check("midclear_restart_en", o_wr_en, 1);
        check("midclear_restart_idx", o_idx, 0);
        for (int i = 0; i < NIDX; i++) tick();

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 599) != 0);
            bus.tbl_ready = ($urandom_range(0, 9) < 7);
            bus.flush_req = ($urandom_range(0, 199) == 0);
            bus.ex_valid = $urandom_range(0, 1);
            bus.ex_pc = BASE | 32'($urandom_range(0, 7) << 3) | 32'($urandom_range(0, 3) << 9);
            bus.ex_tpc = $urandom;
            bus.ex_taken = $urandom_range(0, 1);
            bus.ex_dir_fail = $urandom_range(0, 1);
            bus.ex_add_fail = $urandom_range(0, 1);
            bus.pd_valid = ($urandom_range(0, 9) < 3);
            bus.pd_pc = $urandom;
            bus.pd_btype = 2'($urandom_range(0, 3));
            tick();
        end
        idle();
        rstn = 1;
        tick();

`ifdef BTB_UPD_STAT_EN
        check("stat_wr_cnt", stat_wr_cnt, m_stat_wr);
        check("stat_drop_cnt", stat_drop_cnt, m_stat_drop);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btb_update_sched.md
# btb_update_sched

Update scheduler for the branch target buffer's single write port. Collects misprediction updates from EX and pre-decode corrections from IF1, buffers them, arbitrates them onto the table write port, and sequences a full-table clear after reset or on flush request. Sits between the EX/pre-decoder and the BTB storage arrays; fetch-side lookup is untouched.

## Interface
- PC_INDEX_WIDTH, 6, table index width; index = pc[PC_INDEX_WIDTH+2:3]
- TAG_WIDTH, 8, tag = pc[PC_INDEX_WIDTH+TAG_WIDTH+2:PC_INDEX_WIDTH+3]
- FIFO_DEPTH, 4, EX update queue entries (power of two, >=2)
- STARVE_LIMIT, 3, cycles a pending pre-decode update may lose arbitration before forced grant
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX branch resolution valid
- ex_pc  in  32  resolved branch PC
- ex_tpc  in  32  resolved target PC
- ex_taken  in  1  branch actually taken
- ex_dir_fail  in  1  direction mispredicted
- ex_add_fail  in  1  target mispredicted
- pd_valid  in  1  pre-decode correction valid
- pd_pc  in  32  pre-decoded instruction PC
- pd_btype  in  2  00 none, 01 uncond, 10 PC-relative, 11 indirect
- pd_ready  out  1  pre-decode holding register free
- flush_req  in  1  pulse: invalidate whole table
- clear_busy  out  1  clear sequence in progress
- tbl_ready  in  1  table write port free this cycle
- wr_en  out  1  write request
- wr_index  out  PC_INDEX_WIDTH  entry index
- wr_tag  out  TAG_WIDTH  entry tag
- wr_target  out  30  target PC [31:2]
- wr_taken  out  1  taken bit / counter update direction
- wr_btype  out  2  branch type
- wr_valid  out  1  entry valid bit (0 during clear)
- wr_src  out  1  0 EX, 1 pre-decode
- ex_drop  out  1  pulse: EX update discarded

## Operation
- FSM states CLEAR, RUN. Reset -> CLEAR, clear counter 0.
- CLEAR: wr_en=1, wr_valid=0, wr_index=counter, other wr_* = 0; counter++ on each transfer (wr_en&&tbl_ready); transfer at index 2^PC_INDEX_WIDTH-1 -> RUN. clear_busy=1, pd_ready=0; qualifying EX updates dropped (ex_drop=1).
- flush_req in RUN: FIFO and pd register emptied, -> CLEAR, counter 0. flush_req in CLEAR: counter restarts at 0.
- EX enqueue qualifies when ex_valid && (ex_dir_fail || ex_add_fail); stores index, tag, tpc[31:2], ex_taken, btype=10.
- Coalescing: if FIFO nonempty and newest entry has same index and is not popped this cycle, overwrite it instead of pushing.
- Full: push with no same-cycle pop -> dropped, ex_drop=1. Push and pop same cycle while full -> accepted.
- Pre-decode: pd_valid&&pd_ready loads holding register (wr_taken = pd_btype[0], wr_target=0, wr_valid = pd_btype!=00); pd_ready = RUN && register empty.
- Arbitration (RUN): pd wins if pending and (FIFO empty or starve_cnt==STARVE_LIMIT); else FIFO head. starve_cnt increments each cycle pd pending and loses while EX granted, saturates at STARVE_LIMIT, clears on pd grant.
- wr_* are combinational from the selected source; wr_en must not depend on tbl_ready. Source popped only on transfer.

## Timing
- Reset values: FIFO empty, pd register empty, starve_cnt 0, ex_drop 0, pd_ready 0, clear_busy 1, wr_en 1 with wr_index 0 in the first cycle after rstn high (wr_en 0 while rstn low).
- Clear with tbl_ready always 1: 2^PC_INDEX_WIDTH cycles; RUN on next cycle.
- EX update accepted at edge N -> wr_en earliest in cycle N+1 (no same-cycle bypass).
- pd accepted at edge N -> wr_en earliest cycle N+1; pd_ready low until the transfer edge.
- ex_drop asserted combinationally in the cycle of the dropped request.
- wr_* held stable while wr_en && !tbl_ready.

## Configuration
- BTB_UPD_STAT_EN defined: adds outputs stat_wr_cnt[31:0] (transfers in RUN) and stat_drop_cnt[31:0] (ex_drop cycles), reset to 0, saturating, unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, PC_INDEX_WIDTH=6, tbl_ready=1 -> 64 writes index 0..63 with wr_valid=0, clear_busy falls after cycle 64, pd_ready=1 in cycle 65.
- tbl_ready=0 in RUN, 5 EX mispredicts at distinct indexes -> 4 queued, 5th ex_drop=1; tbl_ready=1 -> 4 writes in FIFO order.
- Two consecutive EX updates, pc 0x1C000040 tpc 0x1C000100 then 0x1C000040 tpc 0x1C000200, tbl_ready=0 -> single write with wr_target=0x1C000200>>2.
- FIFO kept nonempty, pd_valid pc 0x1C000008 btype 01 -> pd granted after exactly 3 EX transfers, wr_src=1, wr_taken=1.
- flush_req mid-RUN with 2 queued -> queue discarded, clear restarts from index 0, no EX writes issued.
- rstn low for one cycle mid-clear at index 30 -> clear restarts at index 0 next cycle.
